router_input_ctrl: RTL and testbench

ROUTER_INPUT_CTRL -- requirements
Module: router_input_ctrl

---
 rtl/router_input_ctrl.sv | 139 +++++++++++++
 tb/tb_router_input_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_ctrl.sv
// router_input_ctrl -- wormhole router input-port controller.
//
// Sits between one input FIFO and the switch. A header at the FIFO head
// raises a one-hot request toward its lookahead output port. The request is
// held as a packet lock until the tail flit has been forwarded. Malformed
// heads seen while idle are dropped, and they set a sticky error flag.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous reset, active low
//   fifo_empty : input FIFO is empty
//   fifo_data  : flit at the FIFO head; type in [Width-1:Width-2], dir in [NumPorts-1:0]
//   fifo_rdreq : pop the FIFO head this cycle
//   req        : one-hot output-port request to the switch allocator
//   gnt        : one-hot grant from the allocator
//   out_ready  : per-port downstream space
//   out_valid  : one-hot, a flit moves to that port this cycle
//   out_data   : flit being moved (always the FIFO head)
//   err        : sticky protocol error
//   pkt_count  : completed packets, modulo 2^16
module router_input_ctrl #(
  parameter int Width    = 66,
  parameter int NumPorts = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifo_empty,
  input  logic [Width-1:0]    fifo_data,
  output logic                fifo_rdreq,
  output logic [NumPorts-1:0] req,
  input  logic [NumPorts-1:0] gnt,
  input  logic [NumPorts-1:0] out_ready,
  output logic [NumPorts-1:0] out_valid,
  output logic [Width-1:0]    out_data,
  output logic                err,
  output logic [15:0]         pkt_count
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, ACTIVE} state_e;

  state_e              state_q, state_d;
  logic [NumPorts-1:0] dir_q, dir_d;
  logic                err_q, err_d;
  logic [15:0]         cnt_q, cnt_d;
  // Set until the first flit of the packet is forwarded. Any later flit
  // that has the header bit set is a protocol error.
  logic                first_q, first_d;

  logic [1:0]          flit_type;
  logic                is_hdr, is_tail;
  logic [NumPorts-1:0] head_dir;
  logic                dir_ok, granted, ready, xfer;
  logic                rdreq_c;
  logic [NumPorts-1:0] req_c, ov_c;

  // Type encoding: bit1 marks a header, and bit0 marks a tail.
  // A value of 11 is a single-flit packet, which is both.
  assign flit_type = fifo_data[Width-1:Width-2];
  assign is_hdr    = flit_type[1];
  assign is_tail   = flit_type[0];
  assign head_dir  = fifo_data[NumPorts-1:0];
  assign dir_ok    = $onehot(head_dir);
  assign granted   = |(gnt & dir_q);
  assign ready     = |(out_ready & dir_q);
  assign xfer      = (state_q == ACTIVE) && !fifo_empty && granted && ready;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    rdreq_c = 1'b0;
    req_c   = '0;
    ov_c    = '0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (is_hdr && dir_ok) begin
            // The header is not popped here. It becomes the first flit
            // forwarded once the switch grants the request.
            dir_d   = head_dir;
            first_d = 1'b1;
            state_d = WAIT_GNT;
          end else begin
            rdreq_c = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      WAIT_GNT: begin
        req_c = dir_q;
        if (granted) state_d = ACTIVE;
      end
      ACTIVE: begin
        req_c = dir_q;
        if (xfer) begin
          rdreq_c = 1'b1;
          ov_c    = dir_q;
          first_d = 1'b0;
          // A stray header inside a packet is forwarded along the locked
          // path. It is flagged as an error, and dir is left unchanged.
          if (is_hdr && !first_q) err_d = 1'b1;
          if (is_tail) begin
            state_d = IDLE;
            cnt_d   = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      dir_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Handshake outputs are gated by reset. While rst is low they stay quiet
  // immediately, without waiting for the next clock edge.
  assign fifo_rdreq = rst & rdreq_c;
  assign req        = rst ? req_c : '0;
  assign out_valid  = rst ? ov_c  : '0;
  assign out_data   = fifo_data;
  assign err        = err_q;
  assign pkt_count  = cnt_q;

endmodule

// File: tb/tb_router_input_ctrl.sv
module tb_router_input_ctrl;
  localparam int W  = 66;
  localparam int NP = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data;
  logic          fifo_rdreq;
  logic [NP-1:0] req, gnt, out_ready, out_valid;
  logic [W-1:0]  out_data;
  logic          err;
  logic [15:0]   pkt_count;
  logic          gnt_en;

  typedef struct packed {
    logic [NP-1:0] dir;
    logic [W-1:0]  data;
  } exp_t;

  logic [W-1:0] fq[$];
  exp_t         exp_q[$];
  exp_t         mon_e;
  int checks = 0, failures = 0, xfer_cnt = 0, drop_cnt = 0;

  always #5 clk = ~clk;

  // The allocator grants whatever is requested, whenever the grant is enabled.
  assign gnt = gnt_en ? req : '0;

  router_input_ctrl #(.Width(W), .NumPorts(NP)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rdreq(fifo_rdreq), .req(req), .gnt(gnt), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .err(err), .pkt_count(pkt_count)
  );

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [1:0] t, input logic [NP-1:0] d,
                      input logic [NP-1:0] exp_dir, input bit fwd);
    logic [W-1:0] f;
    f = '0;
    f[31:0]  = $urandom;
    f[63:32] = $urandom;
    f[W-1:W-2] = t;
    f[NP-1:0]  = d;
    fq.push_back(f);
    if (fwd) exp_q.push_back('{dir: exp_dir, data: f});
    refresh();
  endtask

  // FIFO model: the head is popped at the edge that ends a cycle with rdreq high.
  always @(posedge clk) begin
    if (fifo_rdreq) begin
      if (fq.size() > 0) fq.delete(0);
      #1;
      refresh();
    end
  end

  // Scoreboard monitor: sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (fifo_rdreq && fifo_empty) begin
        checks++; failures++;
        $display("FAIL rdreq_on_empty: rdreq=1 while fifo_empty=1");
      end
      if (out_valid != '0) begin
        checks++;
        if (!$onehot(out_valid) || fifo_rdreq !== 1'b1) begin
          failures++;
          $display("FAIL xfer_shape: out_valid=%b rdreq=%b, need one-hot and rdreq=1", out_valid, fifo_rdreq);
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_xfer: out_valid=%b data=%h, none expected", out_valid, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_valid !== mon_e.dir || out_data !== mon_e.data) begin
            failures++;
            $display("FAIL xfer_data: got %b/%h expected %b/%h", out_valid, out_data, mon_e.dir, mon_e.data);
          end
        end
        xfer_cnt++;
      end else if (fifo_rdreq) begin
        drop_cnt++;
      end
    end
  end

  // Advance to just after the next rising edge, once the FIFO model has settled.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int max, input string name);
    int k;
    k = 0;
    while (k < max && (fq.size() != 0 || exp_q.size() != 0 || req != '0)) begin
      step();
      k++;
    end
    checks++;
    if (k >= max) begin
      failures++;
      $display("FAIL %s_timeout: fifo=%0d pending=%0d req=%b after %0d cycles", name, fq.size(), exp_q.size(), req, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; gnt_en = 1'b1; out_ready = '1;
    fq.delete(); refresh();
    push(2'b10, 5'b00001, 5'b0, 1'b0);
    repeat (3) begin
      step();
      checks++;
      if (req !== '0 || out_valid !== '0 || fifo_rdreq !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs: req=%b out_valid=%b rdreq=%b, need all 0", req, out_valid, fifo_rdreq);
      end
    end
    checks++;
    if (err !== 1'b0 || pkt_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: err=%b pkt_count=%0d, need 0/0", err, pkt_count);
    end
    fq.delete(); refresh();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [NP-1:0] d;
    d = 5'b00100;
    push(2'b11, d, d, 1'b1);
    step();
    checks++;
    if (req !== d || out_valid !== '0 || fifo_rdreq !== 1'b0) begin
      failures++;
      $display("FAIL single_n1: req=%b ov=%b rdreq=%b, need %b/0/0", req, out_valid, fifo_rdreq, d);
    end
    step();
    checks++;
    if (out_valid !== d || fifo_rdreq !== 1'b1) begin
      failures++;
      $display("FAIL single_n2: ov=%b rdreq=%b, need %b/1", out_valid, fifo_rdreq, d);
    end
    step();
    checks++;
    if (req !== '0 || pkt_count !== 16'd1 || out_valid !== '0) begin
      failures++;
      $display("FAIL single_n3: req=%b pkt_count=%0d ov=%b, need 0/1/0", req, pkt_count, out_valid);
    end
  endtask

  task automatic test_multi_stall();
    logic [NP-1:0] d;
    int x0, k;
    logic [15:0] pc0;
    bit stalled;
    d = 5'b00001; x0 = xfer_cnt; pc0 = pkt_count; stalled = 1'b0; k = 0;
    push(2'b10, d, d, 1'b1);
    push(2'b00, 5'b10101, d, 1'b1);
    push(2'b00, 5'b01010, d, 1'b1);
    push(2'b01, 5'b11111, d, 1'b1);
    while (k < 40 && !(exp_q.size() == 0 && fq.size() == 0 && req == '0)) begin
      step(); k++;
      if (fq.size() != 0) begin
        checks++;
        if (req !== d) begin
          failures++;
          $display("FAIL multi_req_hold: req=%b need %b", req, d);
        end
      end
      if (!stalled && xfer_cnt - x0 == 2) begin
        stalled = 1'b1;
        out_ready[0] = 1'b0;
        #1;
        repeat (2) begin
          checks++;
          if (fifo_rdreq !== 1'b0 || req !== d || out_valid !== '0) begin
            failures++;
            $display("FAIL multi_stall: rdreq=%b req=%b ov=%b, need 0/%b/0", fifo_rdreq, req, out_valid, d);
          end
          step();
        end
        out_ready = '1;
      end
    end
    checks++;
    if (k >= 40 || !stalled) begin
      failures++;
      $display("FAIL multi_timeout: cycles=%0d stalled=%0d", k, stalled);
    end
    checks++;
    if (xfer_cnt - x0 != 4 || pkt_count !== pc0 + 16'd1 || err !== 1'b0) begin
      failures++;
      $display("FAIL multi_totals: xfers=%0d pkt_count=%0d err=%b, need 4/%0d/0", xfer_cnt - x0, pkt_count, err, pc0 + 16'd1);
    end
  endtask

  task automatic test_gnt_wait();
    logic [NP-1:0] d;
    logic [15:0] pc0;
    d = 5'b01000; pc0 = pkt_count;
    gnt_en = 1'b0;
    push(2'b11, d, d, 1'b1);
    step();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (req !== d || fifo_rdreq !== 1'b0 || out_valid !== '0) begin
        failures++;
        $display("FAIL gnt_wait_hold: cycle %0d req=%b rdreq=%b ov=%b", i, req, fifo_rdreq, out_valid);
      end
      step();
    end
    gnt_en = 1'b1;
    #1;
    checks++;
    if (out_valid !== '0) begin
      failures++;
      $display("FAIL gnt_wait_early: ov=%b in grant cycle, need 0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== d || fifo_rdreq !== 1'b1) begin
      failures++;
      $display("FAIL gnt_wait_xfer: ov=%b rdreq=%b, need %b/1", out_valid, fifo_rdreq, d);
    end
    step();
    checks++;
    if (pkt_count !== pc0 + 16'd1) begin
      failures++;
      $display("FAIL gnt_wait_count: pkt_count=%0d need %0d", pkt_count, pc0 + 16'd1);
    end
  endtask

  task automatic test_mid_header();
    logic [NP-1:0] d;
    logic [15:0] pc0;
    d = 5'b00100; pc0 = pkt_count;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL mid_hdr_pre_err: err=%b need 0", err);
    end
    push(2'b10, d, d, 1'b1);
    push(2'b00, 5'b00000, d, 1'b1);
    push(2'b10, 5'b00001, d, 1'b1);
    push(2'b01, 5'b00000, d, 1'b1);
    wait_idle(30, "mid_hdr");
    checks++;
    if (err !== 1'b1 || pkt_count !== pc0 + 16'd1) begin
      failures++;
      $display("FAIL mid_hdr_result: err=%b pkt_count=%0d, need 1/%0d", err, pkt_count, pc0 + 16'd1);
    end
  endtask

  task automatic test_reset_mid();
    logic [NP-1:0] d;
    int x0, k;
    d = 5'b00010; x0 = xfer_cnt; k = 0;
    push(2'b10, d, d, 1'b1);
    repeat (3) push(2'b00, 5'b00000, d, 1'b1);
    push(2'b01, 5'b00000, d, 1'b1);
    while (k < 20 && xfer_cnt - x0 < 2) begin step(); k++; end
    checks++;
    if (k >= 20) begin
      failures++;
      $display("FAIL reset_mid_timeout: xfers=%0d", xfer_cnt - x0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req !== '0 || fifo_rdreq !== 1'b0 || out_valid !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: req=%b rdreq=%b ov=%b, need 0", req, fifo_rdreq, out_valid);
    end
    step();
    checks++;
    if (req !== '0 || fifo_rdreq !== 1'b0 || pkt_count !== 16'd0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_state: req=%b rdreq=%b pkt_count=%0d err=%b", req, fifo_rdreq, pkt_count, err);
    end
    fq.delete(); exp_q.delete(); refresh();
    rst = 1'b1;
    step();
    push(2'b11, 5'b10000, 5'b10000, 1'b1);
    wait_idle(20, "reset_mid_new");
    checks++;
    if (pkt_count !== 16'd1 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_new: pkt_count=%0d err=%b, need 1/0", pkt_count, err);
    end
  endtask

  task automatic test_body_idle();
    int d0;
    d0 = drop_cnt;
    push(2'b00, 5'b00001, 5'b0, 1'b0);
    #1;
    checks++;
    if (fifo_rdreq !== 1'b1 || out_valid !== '0 || req !== '0) begin
      failures++;
      $display("FAIL body_drop: rdreq=%b ov=%b req=%b, need 1/0/0", fifo_rdreq, out_valid, req);
    end
    step();
    checks++;
    if (err !== 1'b1 || req !== '0 || fq.size() != 0 || drop_cnt - d0 != 1) begin
      failures++;
      $display("FAIL body_after: err=%b req=%b fifo=%0d drops=%0d, need 1/0/0/1", err, req, fq.size(), drop_cnt - d0);
    end
  endtask

  task automatic test_bad_dir();
    rst = 1'b0; step(); rst = 1'b1; step();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL bad_dir_pre: err=%b need 0", err);
    end
    push(2'b10, 5'b00110, 5'b0, 1'b0);
    #1;
    checks++;
    if (fifo_rdreq !== 1'b1 || req !== '0) begin
      failures++;
      $display("FAIL bad_dir_drop: rdreq=%b req=%b, need 1/0", fifo_rdreq, req);
    end
    step();
    checks++;
    if (err !== 1'b1 || req !== '0 || fq.size() != 0) begin
      failures++;
      $display("FAIL bad_dir_after: err=%b req=%b fifo=%0d, need 1/0/0", err, req, fq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pc0;
    pc0 = pkt_count;
    push(2'b11, 5'b00001, 5'b00001, 1'b1);
    push(2'b11, 5'b10000, 5'b10000, 1'b1);
    wait_idle(20, "b2b");
    checks++;
    if (pkt_count !== pc0 + 16'd2) begin
      failures++;
      $display("FAIL b2b_count: pkt_count=%0d need %0d", pkt_count, pc0 + 16'd2);
    end
  endtask

  initial begin
    rst = 1'b0; gnt_en = 1'b1; out_ready = '1;
    fq.delete(); refresh();
    test_reset();
    test_single();
    test_multi_stall();
    test_gnt_wait();
    test_mid_header();
    test_reset_mid();
    test_body_idle();
    test_bad_dir();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
